// File: rtl/q_lockstep_checker.sv
// Lockstep checker: compares an RTL flop against its gate-level twin every posedge,
// counts mismatches and captures the first failure. Define Q_LOCKSTEP_XCHECK_EN for a 4-state compare.
module q_lockstep_checker #(
  parameter int unsigned WIDTH         = 1,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned STOP_ON_FAIL  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] ref_q,
  input  logic [WIDTH-1:0] dut_q,
  output logic             mismatch,
  output logic             err,
  output logic             checking,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] first_fail_cyc,
  output logic [WIDTH-1:0] first_fail_ref,
  output logic [WIDTH-1:0] first_fail_dut
);

  localparam int unsigned SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, HALT} state_t;

  state_t           state, state_nx;
  logic [SET_W-1:0] settle_cnt, settle_nx;
  logic             compare_c;
  logic             diff_c;

  // Any differing bit is one mismatch; an unknown 2-state result falls through as a match.
  always_comb begin
    diff_c = 1'b0;
`ifdef Q_LOCKSTEP_XCHECK_EN
    if (ref_q !== dut_q) diff_c = 1'b1;
`else
    if (ref_q != dut_q) diff_c = 1'b1;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_nx;
      settle_cnt <= settle_nx;
    end
  end

  // Next state; the enabling edge counts as the first settle edge
  always_comb begin
    state_nx  = state;
    settle_nx = settle_cnt;
    compare_c = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          if (SETTLE_CYCLES <= 1) begin
            state_nx = CHECK;
          end else begin
            state_nx  = SETTLE;
            settle_nx = SET_W'(1);
          end
        end
      end
      SETTLE: begin
        if (!en) begin
          state_nx  = IDLE;
          settle_nx = '0;
        end else if (settle_cnt == SET_W'(SETTLE_LAST)) begin
          state_nx  = CHECK;
          settle_nx = '0;
        end else begin
          settle_nx = settle_cnt + SET_W'(1);
        end
      end
      CHECK: begin
        if (!en) begin
          state_nx = IDLE;
        end else begin
          compare_c = 1'b1;
          if (diff_c && (STOP_ON_FAIL != 0)) state_nx = HALT;
        end
      end
      HALT:    state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end

  // Registered results, saturating counters and first-failure capture
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch       <= 1'b0;
      err            <= 1'b0;
      checking       <= 1'b0;
      cycle_cnt      <= '0;
      mismatch_cnt   <= '0;
      first_fail_cyc <= '0;
      first_fail_ref <= '0;
      first_fail_dut <= '0;
    end else begin
      checking <= (state_nx == CHECK);
      mismatch <= compare_c & diff_c;
      if (compare_c) begin
        if (cycle_cnt != CNT_MAX) cycle_cnt <= cycle_cnt + CNT_W'(1);
        if (diff_c) begin
          if (mismatch_cnt != CNT_MAX) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
          if (!err) begin
            err            <= 1'b1;
            first_fail_cyc <= cycle_cnt;
            first_fail_ref <= ref_q;
            first_fail_dut <= dut_q;
          end
        end
      end
    end
  end

endmodule
